// File: rtl/high_bit_search_pkg.sv
// Shared constants and elaboration helpers for the high-bit search pipeline.
// Provides mode encodings plus clog2 / next-pow2 / index-width derivation.
package high_bit_search_pkg;

   localparam logic MODE_HIGH = 1'b0;
   localparam logic MODE_LOW  = 1'b1;

   function automatic int hbs_clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   function automatic int hbs_pow2(input int n);
      return 1 << hbs_clog2(n);
   endfunction

   function automatic int hbs_idx_w(input int n);
      return (hbs_clog2(n) < 1) ? 1 : hbs_clog2(n);
   endfunction

endpackage

// File: rtl/hbs_merge_node.sv
// Combinational merge of two sibling search-tree nodes at tree level LVL.
// Ports: i_mode, hi/lo child (found, idx) in; merged (found, idx) out.
module hbs_merge_node
   import high_bit_search_pkg::*;
#(
   parameter int IDX_W = 6,
   parameter int LVL   = 1
) (
   input  logic             i_mode,
   input  logic             i_hi_f,
   input  logic [IDX_W-1:0] i_hi_idx,
   input  logic             i_lo_f,
   input  logic [IDX_W-1:0] i_lo_idx,
   output logic             o_f,
   output logic [IDX_W-1:0] o_idx
);

   logic w_take_hi;

   always_comb begin
      w_take_hi = i_hi_f;
      case (i_mode)
         MODE_HIGH: w_take_hi = i_hi_f;
         MODE_LOW:  w_take_hi = i_hi_f & ~i_lo_f;
         default:   w_take_hi = i_hi_f;
      endcase
   end

   // Child indices only use bits below LVL-1 and are zero when the
   // child found nothing, so an empty subtree always yields idx 0.
   always_comb begin
      o_f            = i_hi_f | i_lo_f;
      o_idx          = w_take_hi ? i_hi_idx : i_lo_idx;
      o_idx[LVL-1]   = w_take_hi;
   end

endmodule

// File: rtl/high_bit_search_pipe.sv
// Pipelined highest/lowest set-bit finder with valid/ready on both sides.
// Ports: clk, rst_n, in_valid/in_ready/input_data/in_mode, out_valid/out_ready/out_idx/out_found.
module high_bit_search_pipe
   import high_bit_search_pkg::*;
#(
   parameter int INPUT_WIDTH      = 64,
   parameter int LEVELS_PER_STAGE = 2,
   parameter int IDX_W            = hbs_idx_w(INPUT_WIDTH)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [INPUT_WIDTH-1:0] input_data,
   input  logic                   in_mode,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [IDX_W-1:0]       out_idx,
   output logic                   out_found
);

   localparam int P     = hbs_pow2(INPUT_WIDTH);
   localparam int LOG_P = hbs_clog2(P);
   localparam int S     = (LOG_P + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;

   logic [S:0]             w_stv;
   logic [S:0]             w_ld;
   logic [P-1:0]           w_pad;
   logic [INPUT_WIDTH-1:0] r_data;
   logic                   r_mode;
   logic                   r_v;
   logic                   w_unused;

   // A stage may load when empty or when its successor loads this cycle,
   // so a full pipe still advances while the consumer drains.
   always_comb begin
      logic l;
      w_ld    = '0;
      l       = ~w_stv[S] | out_ready;
      w_ld[S] = l;
      for (int k = S - 1; k >= 0; k--) begin
         l       = ~w_stv[k] | l;
         w_ld[k] = l;
      end
   end

   assign in_ready = w_ld[0];
   assign w_stv[0] = r_v;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v    <= 1'b0;
         r_data <= '0;
         r_mode <= 1'b0;
      end else if (w_ld[0]) begin
         r_v <= in_valid;
         if (in_valid) begin
            r_data <= input_data;
            r_mode <= in_mode;
         end
      end
   end

   always_comb begin
      w_pad                  = '0;
      w_pad[INPUT_WIDTH-1:0] = r_data;
   end

   for (genvar l = 0; l <= LOG_P; l++) begin : g_lvl
      localparam int N = P >> l;
      logic [N-1:0]     w_f;
      logic [IDX_W-1:0] w_i [N];
      logic             w_m;
      logic             w_v;

      if (l == 0) begin : g_leaf
         assign w_f = w_pad;
         assign w_m = r_mode;
         assign w_v = r_v;
         always_comb begin
            for (int n = 0; n < N; n++) w_i[n] = '0;
         end
      end else begin : g_node
         logic [N-1:0]     w_cf;
         logic [IDX_W-1:0] w_ci [N];

         for (genvar n = 0; n < N; n++) begin : g_n
            hbs_merge_node #(
               .IDX_W (IDX_W),
               .LVL   (l)
            ) u_node (
               .i_mode   (g_lvl[l-1].w_m),
               .i_hi_f   (g_lvl[l-1].w_f[2*n+1]),
               .i_hi_idx (g_lvl[l-1].w_i[2*n+1]),
               .i_lo_f   (g_lvl[l-1].w_f[2*n]),
               .i_lo_idx (g_lvl[l-1].w_i[2*n]),
               .o_f      (w_cf[n]),
               .o_idx    (w_ci[n])
            );
         end

         if ((l % LEVELS_PER_STAGE == 0) || (l == LOG_P)) begin : g_reg
            localparam int K = (l + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;
            logic [N-1:0]     r_f;
            logic [IDX_W-1:0] r_i [N];
            logic             r_m;
            logic             r_sv;

            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  r_sv <= 1'b0;
                  r_m  <= 1'b0;
                  r_f  <= '0;
                  for (int n = 0; n < N; n++) r_i[n] <= '0;
               end else if (w_ld[K]) begin
                  r_sv <= g_lvl[l-1].w_v;
                  // Payload only moves with a real beat so a drained
                  // output keeps its last value.
                  if (g_lvl[l-1].w_v) begin
                     r_f <= w_cf;
                     r_i <= w_ci;
                     r_m <= g_lvl[l-1].w_m;
                  end
               end
            end

            assign w_stv[K] = r_sv;
            assign w_f      = r_f;
            assign w_i      = r_i;
            assign w_m      = r_m;
            assign w_v      = r_sv;
         end else begin : g_comb
            assign w_f = w_cf;
            assign w_i = w_ci;
            assign w_m = g_lvl[l-1].w_m;
            assign w_v = g_lvl[l-1].w_v;
         end
      end
   end

   assign out_valid = g_lvl[LOG_P].w_v;
   assign out_found = g_lvl[LOG_P].w_f[0];
   assign out_idx   = g_lvl[LOG_P].w_i[0];
   assign w_unused  = g_lvl[LOG_P].w_m;

endmodule
